// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin writeback arbiter for the 8x8 register file

module regfile_write_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push_valid,
  input  logic [2:0] i_push_addr,
  input  logic [7:0] i_push_data,
  output logic       o_push_ready,
  input  logic       i_pop,
  output logic       o_head_valid,
  output logic [2:0] o_head_addr,
  output logic [7:0] o_head_data,
  output logic [7:0] o_addr_mask
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       r_addr [DEPTH];
  logic [7:0]       r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // With per-slot valid bits, the tail slot is occupied only when every slot is.
  assign w_full       = r_vld[r_wr_ptr];
  assign o_push_ready = !w_full;
  assign w_push       = i_push_valid && !w_full;
  assign o_head_valid = r_vld[r_rd_ptr];
  assign w_pop        = i_pop && o_head_valid;
  assign o_head_addr  = r_addr[r_rd_ptr];
  assign o_head_data  = r_data[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  always_comb begin
    o_addr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) o_addr_mask[r_addr[i]] = 1'b1;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       we3,
  output logic [2:0] wa3,
  output logic [7:0] wd3,
  output logic [7:0] busy,
  output logic [7:0] drop_count,
  output logic       idle
);
  logic       w_a_head_valid;
  logic [2:0] w_a_head_addr;
  logic [7:0] w_a_head_data;
  logic [7:0] w_a_mask;
  logic       w_b_head_valid;
  logic [2:0] w_b_head_addr;
  logic [7:0] w_b_head_data;
  logic [7:0] w_b_mask;
  logic       w_grant_a;
  logic       w_grant_b;
  logic       w_grant;
  logic [2:0] w_grant_addr;
  logic [7:0] w_grant_data;
  logic [7:0] w_busy;

  logic       r_we3;
  logic [2:0] r_wa3;
  logic [7:0] r_wd3;
  logic [7:0] r_drop_count;
  logic       r_last_grant_b;

  regfile_write_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (a_valid),
    .i_push_addr  (a_addr),
    .i_push_data  (a_data),
    .o_push_ready (a_ready),
    .i_pop        (w_grant_a),
    .o_head_valid (w_a_head_valid),
    .o_head_addr  (w_a_head_addr),
    .o_head_data  (w_a_head_data),
    .o_addr_mask  (w_a_mask)
  );

  regfile_write_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (b_valid),
    .i_push_addr  (b_addr),
    .i_push_data  (b_data),
    .o_push_ready (b_ready),
    .i_pop        (w_grant_b),
    .o_head_valid (w_b_head_valid),
    .o_head_addr  (w_b_head_addr),
    .o_head_data  (w_b_head_data),
    .o_addr_mask  (w_b_mask)
  );

  // On a tie the side that did not win last time gets the slot.
  assign w_grant_a    = w_a_head_valid && (!w_b_head_valid || r_last_grant_b);
  assign w_grant_b    = w_b_head_valid && (!w_a_head_valid || !r_last_grant_b);
  assign w_grant      = w_grant_a || w_grant_b;
  assign w_grant_addr = w_grant_a ? w_a_head_addr : w_b_head_addr;
  assign w_grant_data = w_grant_a ? w_a_head_data : w_b_head_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3          <= 1'b0;
      r_wa3          <= 3'd0;
      r_wd3          <= 8'd0;
      r_drop_count   <= 8'd0;
      r_last_grant_b <= 1'b1;
    end else begin
      r_we3 <= 1'b0;
      if (w_grant) begin
        r_last_grant_b <= w_grant_b;
        if (w_grant_addr != 3'd0) begin
          r_we3 <= 1'b1;
          r_wa3 <= w_grant_addr;
          r_wd3 <= w_grant_data;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  assign w_busy     = w_a_mask | w_b_mask | ({7'd0, r_we3} << r_wa3);
  assign busy       = {w_busy[7:1], 1'b0};
  assign we3        = r_we3;
  assign wa3        = r_wa3;
  assign wd3        = r_wd3;
  assign drop_count = r_drop_count;
  assign idle       = !w_a_head_valid && !w_b_head_valid && !r_we3;
endmodule
